// File: rtl/match_sequencer.sv
// Pong match controller: edge-detects buttons and goal pulses, keeps scores, and sequences serve/play/pause/goal/over.
// Outputs are decoded from registered state only. Inputs are sampled every tick and there is no backpressure.
module match_sequencer #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter int GOAL_HOLD   = 40
) (
  input  logic       dyn_clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       goal_ply1,
  input  logic       goal_ply2,
  output logic       ball_reset,
  output logic       ball_play,
  output logic [3:0] score_ply1,
  output logic [3:0] score_ply2,
  output logic [1:0] winner,
  output logic       serve_to,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_GOAL  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_DELAY - 1);
  localparam logic [7:0] GOAL_LOAD  = 8'(GOAL_HOLD - 1);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_to_q, serve_to_d;
  logic       start_prev_q, pause_prev_q, g1_prev_q, g2_prev_q;

  logic start_edge, pause_edge, g1_edge, g2_edge;

  // Previous values reset high so a level held through reset is not an edge.
  assign start_edge = btn_start & ~start_prev_q;
  assign pause_edge = btn_pause & ~pause_prev_q;
  assign g1_edge    = goal_ply1 & ~g1_prev_q;
  assign g2_edge    = goal_ply2 & ~g2_prev_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    winner_d   = winner_q;
    serve_to_d = serve_to_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_SERVE;
          timer_d = SERVE_LOAD;
        end
      end
      S_SERVE: begin
        if (timer_q == 8'd0) state_d = S_PLAY;
        else                 timer_d = timer_q - 8'd1;
      end
      S_PLAY: begin
        // Simultaneous goals are treated as a void rally and re-served.
        if (g1_edge && g2_edge) begin
          state_d = S_SERVE;
          timer_d = SERVE_LOAD;
        end else if (g1_edge) begin
          score1_d   = score1_q + 4'd1;
          serve_to_d = 1'b1;
          state_d    = S_GOAL;
          timer_d    = GOAL_LOAD;
        end else if (g2_edge) begin
          score2_d   = score2_q + 4'd1;
          serve_to_d = 1'b0;
          state_d    = S_GOAL;
          timer_d    = GOAL_LOAD;
        end else if (pause_edge) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_edge) state_d = S_PLAY;
      end
      S_GOAL: begin
        if (timer_q != 8'd0) begin
          timer_d = timer_q - 8'd1;
        end else if (score1_q == WIN_VAL) begin
          state_d  = S_OVER;
          winner_d = 2'b01;
        end else if (score2_q == WIN_VAL) begin
          state_d  = S_OVER;
          winner_d = 2'b10;
        end else begin
          state_d = S_SERVE;
          timer_d = SERVE_LOAD;
        end
      end
      S_OVER: begin
        if (start_edge) begin
          score1_d   = 4'd0;
          score2_d   = 4'd0;
          winner_d   = 2'b00;
          serve_to_d = 1'b0;
          state_d    = S_SERVE;
          timer_d    = SERVE_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dyn_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= 8'd0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= 2'b00;
      serve_to_q   <= 1'b0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
      g1_prev_q    <= 1'b1;
      g2_prev_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      serve_to_q   <= serve_to_d;
      start_prev_q <= btn_start;
      pause_prev_q <= btn_pause;
      g1_prev_q    <= goal_ply1;
      g2_prev_q    <= goal_ply2;
    end
  end

  // GOAL deliberately drives neither output so the ball freezes in place.
  assign ball_reset = (state_q == S_IDLE) || (state_q == S_SERVE) || (state_q == S_OVER);
  assign ball_play  = (state_q == S_PLAY);
  assign score_ply1 = score1_q;
  assign score_ply2 = score2_q;
  assign winner     = winner_q;
  assign serve_to   = serve_to_q;
  assign state      = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Table-driven bench for match_sequencer: each row gives the inputs for one tick and the outputs expected after that tick.
module tb_match_sequencer;

  logic       dyn_clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b1;
  logic       btn_pause = 1'b0;
  logic       goal_ply1 = 1'b0;
  logic       goal_ply2 = 1'b0;
  logic       ball_reset, ball_play, serve_to;
  logic [3:0] score_ply1, score_ply2;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  always #5 dyn_clk = ~dyn_clk;

  match_sequencer #(.WIN_SCORE(3), .SERVE_DELAY(4), .GOAL_HOLD(2)) dut (
    .dyn_clk    (dyn_clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .goal_ply1  (goal_ply1),
    .goal_ply2  (goal_ply2),
    .ball_reset (ball_reset),
    .ball_play  (ball_play),
    .score_ply1 (score_ply1),
    .score_ply2 (score_ply2),
    .winner     (winner),
    .serve_to   (serve_to),
    .state      (state)
  );

  typedef struct packed {
    logic       rst, start, pause, g1, g2;
    logic [2:0] st;
    logic [3:0] s1, s2;
    logic [1:0] win;
    logic       srv;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] s1, s2;
    logic [1:0] win;
    logic       srv, brst, bplay;
  } obs_t;

  vec_t tbl[$];
  obs_t exp_q[$];

  task automatic add(input logic rst, start, pause, g1, g2,
                     input logic [2:0] st, input logic [3:0] s1, s2,
                     input logic [1:0] win, input logic srv);
    vec_t v;
    v = '{rst, start, pause, g1, g2, st, s1, s2, win, srv};
    tbl.push_back(v);
  endtask

  function automatic obs_t expect_of(input vec_t v);
    obs_t o;
    o.st    = v.st;
    o.s1    = v.s1;
    o.s2    = v.s2;
    o.win   = v.win;
    o.srv   = v.srv;
    o.brst  = (v.st == 3'd0) || (v.st == 3'd1) || (v.st == 3'd5);
    o.bplay = (v.st == 3'd2);
    return o;
  endfunction

  initial begin
    obs_t got, exp_o;
    //   rst s p g1 g2  st  s1 s2 win srv
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // 0 reset with start held
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // held level is not an edge
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);  // 5 start edge -> SERVE
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);  // start edge in SERVE ignored
    add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);  // pause edge in SERVE ignored
    add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0);  // 9 PLAY after 4 SERVE ticks
    add(0, 0, 0, 1, 0, 4, 1, 0, 0, 1);  // 10 long goal_ply1 pulse
    add(0, 0, 0, 1, 0, 4, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0, 1);  // 16
    add(0, 0, 0, 1, 1, 1, 1, 0, 0, 1);  // 17 both goals -> re-serve
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0, 1);  // 21
    add(0, 0, 1, 0, 1, 4, 1, 1, 0, 0);  // 22 goal wins over pause
    add(0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 1, 0, 0);  // 28
    add(0, 0, 1, 0, 0, 3, 1, 1, 0, 0);  // 29 pause
    add(0, 0, 0, 1, 0, 3, 1, 1, 0, 0);  // goal in PAUSE ignored
    add(0, 1, 0, 0, 0, 3, 1, 1, 0, 0);  // start in PAUSE ignored
    add(0, 0, 1, 0, 0, 2, 1, 1, 0, 0);  // resume
    add(0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 4, 1, 2, 0, 0);  // 34
    add(0, 0, 0, 0, 0, 4, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 2, 0, 0);  // 40
    add(0, 0, 0, 0, 1, 4, 1, 3, 0, 0);  // winning goal
    add(0, 0, 0, 0, 0, 4, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 5, 1, 3, 2, 0);  // OVER, player 2 wins
    add(0, 0, 0, 1, 0, 5, 1, 3, 2, 0);  // goal in OVER ignored
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);  // restart clears match
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset mid-SERVE
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge dyn_clk);
      reset     = tbl[i].rst;
      btn_start = tbl[i].start;
      btn_pause = tbl[i].pause;
      goal_ply1 = tbl[i].g1;
      goal_ply2 = tbl[i].g2;
      exp_q.push_back(expect_of(tbl[i]));
      @(posedge dyn_clk);
      #1;
      got   = '{state, score_ply1, score_ply2, winner, serve_to, ball_reset, ball_play};
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL vec%0d got st=%0d s1=%0d s2=%0d win=%b srv=%b brst=%b play=%b exp st=%0d s1=%0d s2=%0d win=%b srv=%b brst=%b play=%b",
                 i, got.st, got.s1, got.s2, got.win, got.srv, got.brst, got.bplay,
                 exp_o.st, exp_o.s1, exp_o.s2, exp_o.win, exp_o.srv, exp_o.brst, exp_o.bplay);
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Match-level controller for the Pong game. It drives the ball-dynamics engine's reset/play inputs, consumes its goal pulses, keeps both scores, and sequences serve, rally, pause, goal celebration and game-over.
- Sits between the debounced user buttons and the ball engine. Runs in the same dyn_clk domain as the ball engine.

Parameters:
- WIN_SCORE, 9, score that ends the match; legal range 1..15.
- SERVE_DELAY, 60, dyn_clk ticks the ball is held at centre before a rally; legal range 1..255.
- GOAL_HOLD, 40, dyn_clk ticks of freeze after a goal; legal range 1..255.

Ports:
- dyn_clk  in  1  dynamic (game-tick) clock.
- reset  in  1  synchronous, active-high; clock dyn_clk.
- btn_start  in  1  debounced start level.
- btn_pause  in  1  debounced play/pause toggle level.
- goal_ply1  in  1  from ball engine; high while player 1 has scored.
- goal_ply2  in  1  from ball engine; high while player 2 has scored.
- ball_reset  out  1  hold ball at centre.
- ball_play  out  1  ball engine may run.
- score_ply1  out  4  player 1 score.
- score_ply2  out  4  player 2 score.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- serve_to  out  1  0 = serve toward player 1, 1 = toward player 2.
- state  out  3  current FSM state code.

Behaviour:
- Edge detection:
  - All four inputs are rising-edge detected against a registered previous value.
  - Previous registers reset to 1, so an input held high through reset never produces an edge.
- FSM states and encodings: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, GOAL=4, OVER=5.
  - Codes 6 and 7 are illegal and go to IDLE on the next clock.
- Outputs are decoded from the registered state only (no input-to-output paths):
  - ball_reset=1 in IDLE, SERVE, OVER.
  - ball_play=1 only in PLAY.
- Reset (any state, including mid-rally) takes effect on the next edge:
  - state=IDLE, scores=0, winner=00, serve_to=0, timer=0, edge registers=1.
- IDLE: a start edge moves to SERVE and loads the timer with SERVE_DELAY-1.
- SERVE:
  - Timer decrements each tick; at timer==0 the next state is PLAY.
  - SERVE therefore lasts exactly SERVE_DELAY cycles.
  - Start, pause and goal edges are ignored.
- PLAY:
  - goal_ply1 edge only: score_ply1+1, serve_to=1 (toward the conceding player), go to GOAL, timer=GOAL_HOLD-1.
  - goal_ply2 edge only: score_ply2+1, serve_to=0, go to GOAL.
  - Both goal edges in the same cycle: no score change, go to SERVE with the timer reloaded.
  - Pause edge with no goal edge: go to PAUSE. A goal edge in the same cycle wins and the pause edge is dropped.
- PAUSE:
  - Pause edge returns to PLAY.
  - Goal and start edges are ignored.
  - Scores are frozen.
- GOAL:
  - Timer counts GOAL_HOLD cycles; ball_reset=0 and ball_play=0, so the ball freezes where it is.
  - At expiry, if score_ply1==WIN_SCORE, go to OVER with winner=01; else if score_ply2==WIN_SCORE, go to OVER with winner=10.
  - Otherwise go to SERVE with the timer loaded with SERVE_DELAY-1.
- OVER:
  - Scores and winner are held.
  - A start edge clears scores and winner, sets serve_to=0, and goes to SERVE.
- Scores are 4-bit and never exceed WIN_SCORE, because OVER is entered before any further increment. No wrap is possible.
- Timer: 8-bit down-counter. It is only loaded on entry to SERVE or GOAL.

Test Plan:
- All tests use WIN_SCORE=3, SERVE_DELAY=4, GOAL_HOLD=2.
- Reset with btn_start held high, then release and keep low -> state=0, ball_reset=1, ball_play=0, scores=0, winner=00; no transition occurs.
- Start pulse at cycle n -> state=1 from n+1 to n+4, state=2 at n+5 with ball_play=1, ball_reset=0.
- In PLAY, 3-cycle goal_ply1 high -> score_ply1=1 exactly once, serve_to=1, state=4 for 2 cycles, then state=1; the long pulse causes no double count.
- In PLAY, goal_ply1 and goal_ply2 rise together -> scores unchanged, state=1. Separately, pause and goal_ply2 rising together -> score_ply2+1, state=4, no PAUSE entered.
- Pause edge in PLAY -> state=3, ball_play=0. A goal pulse during PAUSE -> ignored. Second pause edge -> state=2.
- Three player-2 goals -> after the third GOAL hold, state=5, winner=10, score_ply2=3. A start edge then gives scores=0, winner=00, state=1. A reset asserted mid-SERVE returns to IDLE next cycle.
